// File: rtl/nco_clk_gen.sv
// Phase-accumulator clock generator: square-wave output with edge strobes,
// edge counter and an edge-aligned runtime retune over a valid/ready handshake.
module nco_clk_gen #(
  parameter int unsigned      ACC_W       = 32,
  parameter int unsigned      CNT_W       = 16,
  parameter logic [ACC_W-1:0] DEFAULT_FCW = ACC_W'(32'h170A3D71)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             tune_valid,
  output logic             tune_ready,
  input  logic [ACC_W-1:0] tune_fcw,
  output logic [ACC_W-1:0] fcw_active,
  output logic             clk_out,
  output logic             rise_tick,
  output logic             fall_tick,
  output logic [CNT_W-1:0] edge_cnt
);

  // Largest FCW that still yields two accumulator states per output period
  localparam logic [ACC_W-1:0] NYQ_FCW = {1'b1, {(ACC_W-1){1'b0}}};

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] fcw_q, fcw_d;
  logic [ACC_W-1:0] pend_fcw_q, pend_fcw_d;
  logic             pending_q, pending_d;
  logic             ready_q, ready_d;
  logic             clk_out_q, clk_out_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ACC_W-1:0] acc_sum;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q      <= '0;
      fcw_q      <= DEFAULT_FCW;
      pend_fcw_q <= '0;
      pending_q  <= 1'b0;
      ready_q    <= 1'b1;
      clk_out_q  <= 1'b0;
      rise_q     <= 1'b0;
      fall_q     <= 1'b0;
      cnt_q      <= '0;
    end else begin
      acc_q      <= acc_d;
      fcw_q      <= fcw_d;
      pend_fcw_q <= pend_fcw_d;
      pending_q  <= pending_d;
      ready_q    <= ready_d;
      clk_out_q  <= clk_out_d;
      rise_q     <= rise_d;
      fall_q     <= fall_d;
      cnt_q      <= cnt_d;
    end
  end

  always_comb begin
    acc_d      = acc_q;
    fcw_d      = fcw_q;
    pend_fcw_d = pend_fcw_q;
    pending_d  = pending_q;
    clk_out_d  = clk_out_q;
    cnt_d      = cnt_q;
    acc_sum    = acc_q + fcw_q;

    if (en) begin
      acc_d     = acc_sum;
      clk_out_d = acc_sum[ACC_W-1];
    end else begin
      acc_d     = '0;
      clk_out_d = 1'b0;
    end

    rise_d = clk_out_d & ~clk_out_q;
    fall_d = ~clk_out_d & clk_out_q;

    if (rise_d) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    // Apply on a rising edge so the old period always completes
    if (pending_q && (!en || rise_d)) begin
      fcw_d     = pend_fcw_q;
      pending_d = 1'b0;
    end

    if (tune_valid && ready_q) begin
      pending_d  = 1'b1;
      pend_fcw_d = (tune_fcw > NYQ_FCW) ? NYQ_FCW : tune_fcw;
    end

    ready_d = ~pending_d;
  end

  assign tune_ready = ready_q;
  assign fcw_active = fcw_q;
  assign clk_out    = clk_out_q;
  assign rise_tick  = rise_q;
  assign fall_tick  = fall_q;
  assign edge_cnt   = cnt_q;

endmodule

// File: tb/tb_nco_clk_gen.sv
// Bench for nco_clk_gen: directed scenarios plus random traffic, every cycle
// compared against a phase/frequency reference model.
module tb_nco_clk_gen;

  localparam int unsigned ACC_W = 8;
  localparam int unsigned CNT_W = 4;
  localparam int          MOD   = 256;
  localparam int          HALF  = 128;
  localparam int          CMOD  = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             en;
  logic             tune_valid;
  logic             tune_ready;
  logic [ACC_W-1:0] tune_fcw;
  logic [ACC_W-1:0] fcw_active;
  logic             clk_out;
  logic             rise_tick;
  logic             fall_tick;
  logic [CNT_W-1:0] edge_cnt;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  int m_phase, m_fcw, m_pword, m_cnt;
  bit m_pending, m_clk, m_rise, m_fall;

  always #5 clk = ~clk;

  nco_clk_gen #(
    .ACC_W      (ACC_W),
    .CNT_W      (CNT_W),
    .DEFAULT_FCW(8'd64)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .tune_valid(tune_valid),
    .tune_ready(tune_ready),
    .tune_fcw  (tune_fcw),
    .fcw_active(fcw_active),
    .clk_out   (clk_out),
    .rise_tick (rise_tick),
    .fall_tick (fall_tick),
    .edge_cnt  (edge_cnt)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s @%0t: got %0d expected %0d", tag, $time, obs, exp);
    end
  endtask

  // One system-clock cycle of the specified behaviour, from the inputs seen at the edge
  task automatic model_update();
    bit new_clk, accept;
    if (!rst_n) begin
      m_phase = 0; m_fcw = 64; m_pword = 0; m_cnt = 0;
      m_pending = 0; m_clk = 0; m_rise = 0; m_fall = 0;
    end else begin
      if (en) begin
        m_phase = (m_phase + m_fcw) % MOD;
        new_clk = (m_phase >= HALF);
      end else begin
        m_phase = 0;
        new_clk = 0;
      end
      m_rise = new_clk && !m_clk;
      m_fall = !new_clk && m_clk;
      if (m_rise) m_cnt = (m_cnt + 1) % CMOD;
      accept = tune_valid && !m_pending;
      if (m_pending && (!en || m_rise)) begin
        m_fcw = m_pword;
        m_pending = 0;
      end
      if (accept) begin
        m_pending = 1;
        m_pword = (int'(tune_fcw) > HALF) ? HALF : int'(tune_fcw);
      end
      m_clk = new_clk;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    check_eq("clk_out", 32'(clk_out), 32'(m_clk));
    check_eq("rise_tick", 32'(rise_tick), 32'(m_rise));
    check_eq("fall_tick", 32'(fall_tick), 32'(m_fall));
    check_eq("edge_cnt", 32'(edge_cnt), 32'(m_cnt));
    check_eq("fcw_active", 32'(fcw_active), 32'(m_fcw));
    check_eq("tune_ready", 32'(tune_ready), 32'(!m_pending));
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic offer(input int word);
    tune_valid = 1'b1;
    tune_fcw   = 8'(word);
    step();
    tune_valid = 1'b0;
  endtask

  task automatic wait_clk_hi(input string tag);
    int k;
    k = 0;
    while (clk_out !== 1'b1 && k < 20) begin
      step();
      k++;
    end
    check_eq(tag, 32'(clk_out), 32'd1);
  endtask

  initial begin
    m_phase = 0; m_fcw = 64; m_pword = 0; m_cnt = 0;
    m_pending = 0; m_clk = 0; m_rise = 0; m_fall = 0;
    rst_n = 1'b0; en = 1'b0; tune_valid = 1'b0; tune_fcw = '0;

    // Reset state
    steps(2);
    check_eq("rst_fcw", 32'(fcw_active), 32'd64);
    check_eq("rst_ready", 32'(tune_ready), 32'd1);

    // FCW=64: period 4, first rise on 2nd enabled cycle
    rst_n = 1'b1; en = 1'b1;
    step();
    check_eq("first_cycle_low", 32'(clk_out), 32'd0);
    step();
    check_eq("first_rise", 32'(rise_tick), 32'd1);
    steps(14);
    check_eq("cnt_after16", 32'(edge_cnt), 32'd4);

    // Retune to 128 while parked
    en = 1'b0;
    step();
    offer(128);
    steps(2);
    check_eq("fcw_128", 32'(fcw_active), 32'd128);
    en = 1'b1;
    steps(8);

    // Back to 64, then offer 32 during the low phase
    offer(64);
    steps(6);
    check_eq("fcw_64", 32'(fcw_active), 32'd64);
    while (clk_out !== 1'b0 && n_checks < 100000) step();
    offer(32);
    check_eq("ready_low_pending", 32'(tune_ready), 32'd0);
    steps(24);
    check_eq("fcw_32", 32'(fcw_active), 32'd32);

    // Clamp above Nyquist
    offer(200);
    steps(10);
    check_eq("fcw_clamped", 32'(fcw_active), 32'd128);

    // Park while high
    steps(3);
    wait_clk_hi("wait_hi");
    en = 1'b0;
    step();
    check_eq("park_fall", 32'(fall_tick), 32'd1);
    steps(2);

    // Reset mid-run with pending word
    en = 1'b1;
    steps(3);
    offer(16);
    rst_n = 1'b0;
    step();
    check_eq("rst_mid_fcw", 32'(fcw_active), 32'd64);
    check_eq("rst_mid_ready", 32'(tune_ready), 32'd1);

    // 17 rises wrap a 4-bit counter to 1
    rst_n = 1'b1;
    steps(66);
    check_eq("cnt_wrap", 32'(edge_cnt), 32'd1);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      rst_n      = ($urandom_range(0, 149) != 0);
      en         = ($urandom_range(0, 9) != 0);
      tune_valid = ($urandom_range(0, 7) == 0);
      tune_fcw   = 8'($urandom_range(0, 255));
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
